// File: rtl/adc_capture_sequencer.sv
// Trigger-based ADC capture: writes pre/post-trigger samples into a circular
// buffer, then replays the captured window through a valid/ready read port.
module adc_capture_sequencer #(
    parameter int unsigned AW           = 12,
    parameter int unsigned AUTO_TIMEOUT = 2500000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    sample,
    input  logic          arm,
    input  logic          abort,
    input  logic [7:0]    trig_level,
    input  logic [7:0]    trig_hyst,
    input  logic          trig_slope,
    input  logic          trig_mode,
    input  logic [AW-1:0] pre_len,
    input  logic [AW:0]   post_len,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last,
    output logic          busy,
    output logic          triggered,
    output logic          auto_fired,
    output logic          done,
    output logic          cfg_err
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned TW    = 32;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pre_q, pre_d;
    logic [AW:0]   post_q, post_d;
    logic [7:0]    level_q, level_d, hyst_q, hyst_d;
    logic          slope_q, slope_d, mode_q, mode_d;
    logic [AW:0]   cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          qual_q, qual_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic          busy_q, busy_d, trig_q, trig_d, auto_q, auto_d;
    logic          done_q, done_d, cfg_err_q, cfg_err_d;

    logic [7:0]    lo_c, hi_c;
    logic [8:0]    hi_sum_c;
    logic          qual_set_c, real_trig_c, timeout_c, cfg_bad_c;
    logic [AW+1:0] total_c;

    // Hysteresis thresholds, saturating at the 8-bit range ends.
    always_comb begin
        lo_c        = (level_q > hyst_q) ? (level_q - hyst_q) : 8'd0;
        hi_sum_c    = 9'(level_q) + 9'(hyst_q);
        hi_c        = hi_sum_c[8] ? 8'hFF : hi_sum_c[7:0];
        qual_set_c  = slope_q ? (wr_data_q < lo_c) : (wr_data_q > hi_c);
        real_trig_c = qual_q && (slope_q ? (wr_data_q > level_q) : (wr_data_q < level_q));
        timeout_c   = mode_q && (timer_q == TW'(AUTO_TIMEOUT - 1));
        total_c     = (AW+2)'(pre_q) + (AW+2)'(post_q);
        cfg_bad_c   = (post_len == '0) ||
                      (((AW+2)'(pre_len) + (AW+2)'(post_len)) > (AW+2)'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        post_d     = post_q;
        level_d    = level_q;
        hyst_d     = hyst_q;
        slope_d    = slope_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        timer_d    = timer_q;
        qual_d     = qual_q;
        rd_addr_d  = rd_addr_q;
        rd_last_d  = rd_last_q;
        trig_d     = trig_q;
        auto_d     = auto_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        wr_data_d  = sample;
        wr_addr_d  = wr_en_q ? (wr_addr_q + AW'(1)) : wr_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    pre_d   = pre_len;
                    post_d  = post_len;
                    level_d = trig_level;
                    hyst_d  = trig_hyst;
                    slope_d = trig_slope;
                    mode_d  = trig_mode;
                    if (cfg_bad_c) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        trig_d = 1'b0;
                        auto_d = 1'b0;
                        cnt_d  = '0;
                        if (pre_len == '0) begin
                            state_d = S_WAIT;
                            timer_d = '0;
                            qual_d  = 1'b0;
                        end else begin
                            state_d = S_PRE;
                        end
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == ((AW+1)'(pre_q) - (AW+1)'(1))) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                    qual_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + (AW+1)'(1);
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                qual_d  = qual_q | qual_set_c;
                if (real_trig_c || timeout_c) begin
                    // The trigger sample is already being written: it is post sample 1.
                    trig_d    = 1'b1;
                    auto_d    = !real_trig_c;
                    rd_addr_d = wr_addr_q - pre_q;
                    cnt_d     = (AW+1)'(1);
                    if (post_q == (AW+1)'(1)) begin
                        state_d   = S_READ;
                        rd_cnt_d  = '0;
                        rd_last_d = (total_c == (AW+2)'(1));
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if ((cnt_q + (AW+1)'(1)) == post_q) begin
                    state_d   = S_READ;
                    rd_cnt_d  = '0;
                    rd_last_d = (total_c == (AW+2)'(1));
                end else begin
                    cnt_d = cnt_q + (AW+1)'(1);
                end
            end
            S_READ: begin
                if (rd_ready) begin
                    if (rd_last_q) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        rd_last_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        rd_cnt_d  = rd_cnt_q + (AW+1)'(1);
                        rd_last_d = (((AW+2)'(rd_cnt_q) + (AW+2)'(2)) == total_c);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            rd_last_d = 1'b0;
        end

        wr_en_d    = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
        rd_valid_d = (state_d == S_READ);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            level_q    <= '0;
            hyst_q     <= '0;
            slope_q    <= 1'b0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            timer_q    <= '0;
            qual_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
            auto_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            level_q    <= level_d;
            hyst_q     <= hyst_d;
            slope_q    <= slope_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            timer_q    <= timer_d;
            qual_q     <= qual_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            trig_q     <= trig_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_addr    = rd_addr_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign busy       = busy_q;
    assign triggered  = trig_q;
    assign auto_fired = auto_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameter AW, default 12, buffer address width; DEPTH = 2^AW samples.
REQ-002 Parameter AUTO_TIMEOUT, default 2500000, cycles in WAIT before auto-trigger.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sample  in  8  ADC sample, one per clk.
REQ-006 arm  in  1  single-cycle start request.
REQ-007 abort  in  1  cancel capture or readout.
REQ-008 trig_level  in  8  trigger threshold.
REQ-009 trig_hyst  in  8  hysteresis band.
REQ-010 trig_slope  in  1  1 = rising, 0 = falling.
REQ-011 trig_mode  in  1  0 = normal, 1 = auto.
REQ-012 pre_len  in  AW  samples kept before trigger.
REQ-013 post_len  in  AW+1  samples from trigger onward, trigger sample included.
REQ-014 wr_en / wr_addr / wr_data  out  1 / AW / 8  buffer write port.
REQ-015 rd_addr  out  AW, rd_valid  out  1, rd_ready  in  1, rd_last  out  1  readout handshake.
REQ-016 busy, triggered, auto_fired, done, cfg_err  out  1 each  status.

Function
REQ-017 States: IDLE, PRE, WAIT, POST, READ; one state per cycle, registered outputs.
REQ-018 IDLE: arm=1 latches all config inputs; if post_len==0 or pre_len+post_len>DEPTH, pulse cfg_err 1 cycle and stay IDLE; else go PRE (or WAIT if pre_len==0), clear triggered/auto_fired.
REQ-019 arm outside IDLE ignored; config inputs changes after latch ignored.
REQ-020 wr_data = sample delayed 1 clk; wr_en=1 in PRE, WAIT, POST; wr_addr increments modulo DEPTH after every write, starting at 0 after reset and continuing from last value across captures.
REQ-021 PRE: write exactly pre_len samples (trigger ignored), then WAIT.
REQ-022 Qualifier (rising): qual set when wr_data < max(trig_level-trig_hyst,0) saturating; trigger when qual=1 and wr_data > trig_level. Falling: mirror with min(trig_level+trig_hyst,255).
REQ-023 qual cleared on WAIT entry; only samples written in WAIT qualify or trigger.
REQ-024 Auto: trig_mode=1, WAIT timer reaches AUTO_TIMEOUT with no trigger -> forced trigger that cycle, auto_fired=1; real trigger same cycle wins (auto_fired=0).
REQ-025 On trigger: trig_addr = wr_addr of trigger sample; triggered=1; state POST; that sample is post sample 1.
REQ-026 POST: total post_len samples written (trigger included), then READ; wr_en=0 from the next cycle.
REQ-027 READ: rd_addr starts at (trig_addr - pre_len) mod DEPTH; rd_valid=1; each cycle with rd_valid&rd_ready advances rd_addr by 1 modulo DEPTH.
REQ-028 rd_last=1 on the (pre_len+post_len)-th beat; after its handshake: rd_valid=0, done pulses 1 cycle, IDLE.
REQ-029 rd_addr/rd_last stable while rd_valid=1 and rd_ready=0.
REQ-030 abort in any non-IDLE state: next cycle IDLE, wr_en=0, rd_valid=0, no done; abort beats arm.
REQ-031 busy=1 in every state except IDLE.

Reset
REQ-032 rst=1: state IDLE, wr_addr=0, wr_en=0, rd_valid=0, rd_last=0, busy=0, triggered=0, auto_fired=0, done=0, cfg_err=0, timer and qual cleared; rst overrides arm and abort.
REQ-033 rst mid-capture or mid-readout discards the capture; no done pulse.

Verification
REQ-034 pre=4, post=8, rising, level=150, hyst=50, ramp 0..255 -> trigger at first wr_data=151, 12 beats from trig_addr-4, rd_last on beat 12, done 1 cycle.
REQ-035 trig_mode=1, constant sample=120 -> auto_fired=1 after AUTO_TIMEOUT WAIT cycles; trig_mode=0 same stimulus -> stays WAIT.
REQ-036 wr_addr at DEPTH-2 when arm, pre=4 -> readout addresses wrap DEPTH-1 -> 0 correctly.
REQ-037 pre=3000, post=2000 (DEPTH 4096) -> cfg_err pulse, busy stays 0.
REQ-038 rd_ready toggling 1/0 during READ -> rd_addr holds when not ready, no beat lost or duplicated.
REQ-039 abort in POST, and rst in READ -> IDLE next cycle, no done, rearm completes normally.
